// File: rtl/lsu_pkg.sv
// Shared size codes, FSM state encoding and byte-enable bases for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/load_ext.sv
// Little-endian lane select plus sign/zero extension of a memory read word.
module load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_alo,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_alo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_alo[1] ? i_rdata[31:16] : i_rdata[15:0];

        // Reserved size code behaves as a full word.
        if (i_size == SZ_BYTE)
            o_data = {{24{i_sext & w_byte[7]}}, w_byte};
        else if (i_size == SZ_HALF)
            o_data = {{16{i_sext & w_half[15]}}, w_half};
        else
            o_data = i_rdata;
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between MEM stage and data memory: store lane packing, load extension,
// IDLE/ACCESS/RESP handshake. MEM_LSU_MISALIGN_TRAP_EN enables the misalignment trap.
module mem_lsu
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_sext,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_mem_en,
    output logic [3:0]  o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    lsu_state_t  r_state, w_next;
    logic        r_we, r_sext;
    logic [1:0]  r_size, r_alo;
    logic        r_mem_en, r_rsp_valid, r_rsp_err;
    logic [3:0]  r_mem_we;
    logic [31:0] r_mem_addr, r_mem_wdata, r_rsp_rdata;

    logic        w_misalign;
    logic [1:0]  w_alo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ld;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign w_alo = i_req_addr[1:0];
    always_comb begin
        w_misalign = 1'b0;
        if (i_req_size == SZ_HALF)
            w_misalign = i_req_addr[0];
        else if (i_req_size != SZ_BYTE)
            w_misalign = (i_req_addr[1:0] != 2'b00);
    end
`else
    // Without the trap, low address bits below the access size are simply dropped.
    assign w_misalign = 1'b0;
    always_comb begin
        w_alo = 2'b00;
        if (i_req_size == SZ_BYTE)
            w_alo = i_req_addr[1:0];
        else if (i_req_size == SZ_HALF)
            w_alo = {i_req_addr[1], 1'b0};
    end
`endif

    always_comb begin
        if (i_req_size == SZ_BYTE) begin
            w_be    = BE_BYTE << w_alo;
            w_wdata = {4{i_req_wdata[7:0]}};
        end else if (i_req_size == SZ_HALF) begin
            w_be    = BE_HALF << w_alo;
            w_wdata = {2{i_req_wdata[15:0]}};
        end else begin
            w_be    = BE_WORD;
            w_wdata = i_req_wdata;
        end
    end

    load_ext u_load_ext (
        .i_rdata (i_mem_rdata),
        .i_alo   (r_alo),
        .i_size  (r_size),
        .i_sext  (r_sext),
        .o_data  (w_ld)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_req_valid) w_next = w_misalign ? RESP : ACCESS;
            ACCESS:  if (i_mem_ack)   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_we        <= 1'b0;
            r_sext      <= 1'b0;
            r_size      <= SZ_BYTE;
            r_alo       <= 2'b00;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 4'b0000;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: if (i_req_valid) begin
                    r_we   <= i_req_we;
                    r_sext <= i_req_sext;
                    r_size <= i_req_size;
                    r_alo  <= w_alo;
                    if (w_misalign) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                    end else begin
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= {i_req_addr[31:2], 2'b00};
                        r_mem_we    <= i_req_we ? w_be : 4'b0000;
                        r_mem_wdata <= w_wdata;
                    end
                end
                ACCESS: if (i_mem_ack) begin
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 4'b0000;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= r_we ? 32'h0 : w_ld;
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu; one task per scenario.
module tb_mem_lsu;

    logic        clk, reset;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_en, mem_ack;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int tests = 0;
    int fails = 0;

    mem_lsu dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_size  (req_size),
        .i_req_sext  (req_sext),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request during cycle 0; returns 1 time unit into cycle 1.
    task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_we    = we;
        req_size  = size;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
        tests++; if (mem_we !== 4'b0000) begin fails++; $display("FAIL reset_mem_we got %b want 0000", mem_we); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_load_byte_signed();
        issue(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0);
        tests++; if (mem_en !== 1'b1) begin fails++; $display("FAIL lb_mem_en got %b want 1", mem_en); end
        tests++; if (mem_addr !== 32'h0000_1000) begin fails++; $display("FAIL lb_mem_addr got %h want 00001000", mem_addr); end
        tests++; if (mem_we !== 4'b0000) begin fails++; $display("FAIL lb_mem_we got %b want 0000", mem_we); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL lb_ready_access got %b want 0", req_ready); end
        mem_rdata = 32'h80FF_1234;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL lb_rsp_valid got %b want 1", rsp_valid); end
        tests++; if (rsp_rdata !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_rsp_rdata got %h want ffffff80", rsp_rdata); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL lb_rsp_err got %b want 0", rsp_err); end
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL lb_mem_en_drop got %b want 0", mem_en); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL lb_ready_resp got %b want 0", req_ready); end
        step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL lb_rsp_pulse got %b want 0", rsp_valid); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL lb_ready_idle got %b want 1", req_ready); end
    endtask

    task automatic test_load_half();
        issue(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0);
        mem_rdata = 32'hBEEF_0001;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL lhu_rsp_valid got %b want 1", rsp_valid); end
        tests++; if (rsp_rdata !== 32'h0000_BEEF) begin fails++; $display("FAIL lhu_rsp_rdata got %h want 0000beef", rsp_rdata); end
        step();
        issue(1'b0, 2'b01, 1'b1, 32'h0000_3000, 32'h0);
        mem_rdata = 32'h1234_8001;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        tests++; if (rsp_rdata !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_rsp_rdata got %h want ffff8001", rsp_rdata); end
        step();
    endtask

    task automatic test_store_byte();
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h1234_56AB);
        tests++; if (mem_addr !== 32'h0000_0004) begin fails++; $display("FAIL sb_mem_addr got %h want 00000004", mem_addr); end
        tests++; if (mem_we !== 4'b0010) begin fails++; $display("FAIL sb_mem_we got %b want 0010", mem_we); end
        tests++; if (mem_wdata !== 32'hABAB_ABAB) begin fails++; $display("FAIL sb_mem_wdata got %h want abababab", mem_wdata); end
        mem_rdata = 32'hDEAD_BEEF;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL sb_rsp_valid got %b want 1", rsp_valid); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL sb_rsp_rdata got %h want 0", rsp_rdata); end
        step();
    endtask

    task automatic test_store_half_wait();
        issue(1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h0000_C0DE);
        for (int c = 1; c <= 3; c++) begin
            tests++; if (mem_en !== 1'b1) begin fails++; $display("FAIL sh_hold_en cyc%0d got %b want 1", c, mem_en); end
            tests++; if (mem_we !== 4'b1100) begin fails++; $display("FAIL sh_hold_we cyc%0d got %b want 1100", c, mem_we); end
            tests++; if (mem_wdata !== 32'hC0DE_C0DE) begin fails++; $display("FAIL sh_hold_wdata cyc%0d got %h want c0dec0de", c, mem_wdata); end
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL sh_early_rsp cyc%0d got %b want 0", c, rsp_valid); end
            step();
        end
        tests++; if (mem_addr !== 32'h0000_0008) begin fails++; $display("FAIL sh_mem_addr got %h want 00000008", mem_addr); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL sh_rsp_cyc5 got %b want 1", rsp_valid); end
        step();
    endtask

    task automatic test_misaligned();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL mis_mem_en got %b want 0", mem_en); end
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mis_rsp_valid got %b want 1", rsp_valid); end
        tests++; if (rsp_err !== 1'b1) begin fails++; $display("FAIL mis_rsp_err got %b want 1", rsp_err); end
        step();
`else
        tests++; if (mem_en !== 1'b1) begin fails++; $display("FAIL mis_mem_en got %b want 1", mem_en); end
        tests++; if (mem_addr !== 32'h0000_0004) begin fails++; $display("FAIL mis_mem_addr got %h want 00000004", mem_addr); end
        mem_rdata = 32'hCAFE_F00D;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mis_rsp_valid got %b want 1", rsp_valid); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL mis_rsp_err got %b want 0", rsp_err); end
        tests++; if (rsp_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL mis_rsp_rdata got %h want cafef00d", rsp_rdata); end
        step();
`endif
    endtask

    task automatic test_reset_mid_access();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        tests++; if (mem_en !== 1'b1) begin fails++; $display("FAIL rst_pre_en got %b want 1", mem_en); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL rst_en_drop got %b want 0", mem_en); end
        step();
        reset   = 1'b0;
        mem_ack = 1'b1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", req_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            mem_ack = 1'b0;
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_no_rsp cyc%0d got %b want 0", c, rsp_valid); end
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_sext  = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        test_reset();
        test_load_byte_signed();
        test_load_half();
        test_store_byte();
        test_store_half_wait();
        test_misaligned();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
